csr_access_unit: RTL
====================

// Module: csr_access_unit
// PURPOSE
//  - Initiator side of the CSR file interface; executes Zicsr ops (CSRRW/RS/RC, CSRRWI/RSI/RCI).
//  - Takes a decoded CSR op from the core control path and runs a read-modify-write on the CSR file.
//  - Returns the old CSR value for rd with a one-cycle done pulse.
//  - Sits between the instruction decoder/control FSM and the CSR register file.
// PARAMETERS
//  XLEN          32  data width
//  READ_LATENCY  1   clock edges from address drive to valid csr_rdata (1..3)
// PORTS
//  clk        in   1     system clock
//  resetn     in   1     asynchronous active-low reset
//  start      in   1     op request; accepted only when ready=1
//  ready      out  1     unit idle, can accept start
//  funct3     in   3     Zicsr funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
//  csr_num    in   12    CSR number from instr[31:20]
//  rs1_val    in   XLEN  rs1 register value (register forms)
//  rs1_idx    in   5     rs1 field; doubles as zimm for immediate forms
//  csr_addr   out  32    byte address to CSR file = {18'b0, csr_num, 2'b00}
//  csr_wdata  out  XLEN  write data to CSR file
//  csr_we     out  1     CSR write strobe, exactly one cycle per write
//  csr_rdata  in   XLEN  CSR file read bus
//  rd_wdata   out  XLEN  old CSR value for rd; valid while done=1
//  done       out  1     one-cycle completion pulse
//  illegal    out  1     one-cycle pulse with done on illegal op
// BEHAVIOUR
//  - Reset (async, resetn=0): state IDLE; ready=1; csr_we=0; done=0; illegal=0;
//    csr_addr=0; csr_wdata=0; rd_wdata=0; internal registers cleared. csr_we drops immediately.
//  - All outputs are registered; no combinational path from inputs to outputs.
//  - IDLE: ready=1. On start, latch funct3, csr_num, operand; go to READ.
//    - Operand is rs1_val (funct3[2]=0) or zero-extended rs1_idx (funct3[2]=1).
//    - start while ready=0 is ignored.
//  - READ: drive csr_addr with csr_we=0; load wait counter with READ_LATENCY-1; go to WAIT.
//  - WAIT: hold csr_addr; count down. At 0, capture csr_rdata into old_q; go to MODIFY.
//  - MODIFY: compute new = RW: operand; RS: old_q | operand; RC: old_q & ~operand.
//    - wr_req = RW forms always; RS/RC forms only if operand field rs1_idx != 0.
//    - If illegal, go to DONE with illegal flag. If wr_req, go to WRITE. Otherwise go to DONE.
//  - WRITE: csr_addr held, csr_wdata=new, csr_we=1 for exactly this cycle; go to DONE.
//  - DONE: done=1; rd_wdata=old_q (0 if illegal); illegal per flag; next cycle IDLE, ready=1.
//  - Illegal op, with no CSR write issued:
//    - funct3[1:0]==00; or
//    - wr_req with csr_num[11:10]==2'b11 (read-only space).
//  - Latency with READ_LATENCY=1, start accepted at edge 0:
//    - READ@1, WAIT@2, MODIFY@3, WRITE@4, done@5.
//    - Without a write, done@4.
//  - Back-to-back: earliest next start is accepted the cycle after done.
//  - Reset mid-op (any state): abort; no partial write. A pending write that has not yet pulsed is dropped.
//  - Operand/old_q widths are XLEN; no sign extension; zimm is zero-extended to XLEN.
// STRUCTURE
//  - Shared package csr_pkg:
//    - funct3 localparams (CSRRW..CSRRCI);
//    - state encoding (IDLE, READ, WAIT, MODIFY, WRITE, DONE);
//    - CSR number constants (MSTATUS 12'h300, MSCRATCH 12'h340, MVENDORID 12'hF11).
//  - Single module; wait counter inline (2 bits). No sub-module needed.
// TESTING
//  1. CSRRW csr_num=0x340, rs1_val=0xDEADBEEF, CSR holds 0x12345678
//     -> csr_addr=0x00000D00; one csr_we with wdata 0xDEADBEEF; rd_wdata=0x12345678; done@5.
//  2. CSRRS csr_num=0x300, rs1_idx=0, CSR=0x00001800
//     -> csr_we never asserted; rd_wdata=0x00001800; done@4.
//  3. CSRRC rs1_val=0x0000000F, old 0xFFFF00FF
//     -> wdata 0xFFFF00F0; CSRRSI zimm=5'h15, old 0x100 -> wdata 0x115.
//  4. CSRRW csr_num=0xF11, rs1_val=1
//     -> illegal=1 with done; no csr_we; rd_wdata=0. funct3=100 -> illegal.
//  5. Assert resetn=0 during WRITE cycle
//     -> csr_we falls asynchronously; ready=1 after release; no done pulse.
//  6. READ_LATENCY=3 build plus start pulsed while busy
//     -> rdata sampled 3 edges after READ; the extra start is ignored (single done).

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the CSR access unit: Zicsr funct3 codes, FSM states,
// well-known CSR numbers and the CSR-number-to-byte-address mapping.
package csr_pkg;

    // Zicsr funct3 encodings
    localparam logic [2:0] F3Csrrw  = 3'b001;
    localparam logic [2:0] F3Csrrs  = 3'b010;
    localparam logic [2:0] F3Csrrc  = 3'b011;
    localparam logic [2:0] F3Csrrwi = 3'b101;
    localparam logic [2:0] F3Csrrsi = 3'b110;
    localparam logic [2:0] F3Csrrci = 3'b111;

    // Frequently used CSR numbers
    localparam logic [11:0] CsrMstatus   = 12'h300;
    localparam logic [11:0] CsrMscratch  = 12'h340;
    localparam logic [11:0] CsrMvendorid = 12'hF11;

    // Access FSM states
    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StModify,
        StWrite,
        StDone
    } state_e;

    // CSR file is word addressed by CSR number
    function automatic logic [31:0] csr_byte_addr(input logic [11:0] num);
        return {18'b0, num, 2'b00};
    endfunction

endpackage

// File: rtl/csr_access_unit.sv
// CSR access unit: runs one Zicsr read-modify-write against the CSR file and
// returns the old CSR value for rd with a single-cycle done pulse.
module csr_access_unit
    import csr_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic            i_clk,
    input  logic            i_resetn,
    input  logic            i_start,
    output logic            o_ready,
    input  logic [2:0]      i_funct3,
    input  logic [11:0]     i_csr_num,
    input  logic [XLEN-1:0] i_rs1_val,
    input  logic [4:0]      i_rs1_idx,
    output logic [31:0]     o_csr_addr,
    output logic [XLEN-1:0] o_csr_wdata,
    output logic            o_csr_we,
    input  logic [XLEN-1:0] i_csr_rdata,
    output logic [XLEN-1:0] o_rd_wdata,
    output logic            o_done,
    output logic            o_illegal
);

    // Wait counter reload: number of extra WAIT cycles before rdata is valid
    localparam logic [1:0] WaitLoad = 2'(READ_LATENCY - 1);

    state_e          r_state;
    state_e          w_state_d;

    // Latched request
    logic [2:0]      r_funct3;
    logic [11:0]     r_csr_num;
    logic [XLEN-1:0] r_operand;
    logic            r_idx_nz;

    // Datapath state
    logic [1:0]      r_cnt;
    logic [XLEN-1:0] r_old;
    logic            r_ill;

    // Registered outputs
    logic            r_ready;
    logic [31:0]     r_csr_addr;
    logic [XLEN-1:0] r_csr_wdata;
    logic            r_csr_we;
    logic [XLEN-1:0] r_rd_wdata;
    logic            r_done;
    logic            r_illegal;

    // MODIFY-stage decode
    logic            w_accept;
    logic            w_wr_req;
    logic            w_illegal;
    logic            w_ill_now;
    logic [XLEN-1:0] w_new;
    logic [XLEN-1:0] w_operand_in;

    assign w_accept     = (r_state == StIdle) && i_start;
    assign w_operand_in = i_funct3[2] ? {{(XLEN - 5){1'b0}}, i_rs1_idx} : i_rs1_val;

    // Write request, legality and new CSR value from the latched op
    always_comb begin
        w_wr_req  = (r_funct3[1:0] == 2'b01) || r_idx_nz;
        w_illegal = (r_funct3[1:0] == 2'b00) ||
                    (w_wr_req && (r_csr_num[11:10] == 2'b11));
        w_new     = r_old;
        case (r_funct3)
            F3Csrrw, F3Csrrwi: w_new = r_operand;
            F3Csrrs, F3Csrrsi: w_new = r_old | r_operand;
            F3Csrrc, F3Csrrci: w_new = r_old & ~r_operand;
            default:           w_new = r_old;
        endcase
        // Illegal flag is only registered on leaving MODIFY, so use the live decode there
        w_ill_now = (r_state == StModify) ? w_illegal : r_ill;
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:   if (i_start) w_state_d = StRead;
            StRead:   w_state_d = StWait;
            StWait:   if (r_cnt == 2'd0) w_state_d = StModify;
            StModify: begin
                if (w_illegal) begin
                    w_state_d = StDone;
                end else if (w_wr_req) begin
                    w_state_d = StWrite;
                end else begin
                    w_state_d = StDone;
                end
            end
            StWrite:  w_state_d = StDone;
            StDone:   w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Request latch, wait counter and old-value capture
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_funct3  <= 3'b000;
            r_csr_num <= 12'h000;
            r_operand <= '0;
            r_idx_nz  <= 1'b0;
            r_cnt     <= 2'd0;
            r_old     <= '0;
            r_ill     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_funct3  <= i_funct3;
                r_csr_num <= i_csr_num;
                r_operand <= w_operand_in;
                r_idx_nz  <= |i_rs1_idx;
                r_ill     <= 1'b0;
            end
            if (r_state == StRead) begin
                r_cnt <= WaitLoad;
            end else if (r_state == StWait) begin
                if (r_cnt == 2'd0) begin
                    r_old <= i_csr_rdata;
                end else begin
                    r_cnt <= r_cnt - 2'd1;
                end
            end
            if (r_state == StModify) begin
                r_ill <= w_illegal;
            end
        end
    end

    // Output registers, driven from the next state so they line up with it
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_ready     <= 1'b1;
            r_csr_addr  <= 32'h0;
            r_csr_wdata <= '0;
            r_csr_we    <= 1'b0;
            r_rd_wdata  <= '0;
            r_done      <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_ready  <= (w_state_d == StIdle);
            r_csr_we <= (w_state_d == StWrite);
            r_done   <= (w_state_d == StDone);
            if (w_accept) begin
                // Address is valid from the READ cycle onward and held until the next op
                r_csr_addr <= csr_byte_addr(i_csr_num);
            end
            if (w_state_d == StWrite) begin
                r_csr_wdata <= w_new;
            end
            if ((w_state_d == StDone) && (r_state != StDone)) begin
                r_rd_wdata <= w_ill_now ? '0 : r_old;
                r_illegal  <= w_ill_now;
            end else begin
                r_illegal  <= 1'b0;
            end
        end
    end

    assign o_ready     = r_ready;
    assign o_csr_addr  = r_csr_addr;
    assign o_csr_wdata = r_csr_wdata;
    assign o_csr_we    = r_csr_we;
    assign o_rd_wdata  = r_rd_wdata;
    assign o_done      = r_done;
    assign o_illegal   = r_illegal;

endmodule
